// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins).
module alu_req_arbiter #(
  parameter int W   = 32,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           REQ0,
  input  logic [W-1:0]   A0,
  input  logic [W-1:0]   B0,
  input  logic [OPW-1:0] OP0,
  output logic           GNT0,
  input  logic           REQ1,
  input  logic [W-1:0]   A1,
  input  logic [W-1:0]   B1,
  input  logic [OPW-1:0] OP1,
  output logic           GNT1,
  output logic [W-1:0]   ALU_A,
  output logic [W-1:0]   ALU_B,
  output logic [OPW-1:0] ALU_OP,
  input  logic [W-1:0]   ALU_F,
  input  logic           ALU_ZF,
  input  logic           ALU_OF,
  output logic           DONE,
  output logic           RES_ID,
  output logic [W-1:0]   RES_F,
  output logic           RES_ZF,
  output logic           RES_OF
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state_q, state_d;
  logic           gnt0_q, gnt0_d;
  logic           gnt1_q, gnt1_d;
  logic           done_q, done_d;
  logic           owner_q, owner_d;
  logic [W-1:0]   alu_a_q, alu_a_d;
  logic [W-1:0]   alu_b_q, alu_b_d;
  logic [OPW-1:0] alu_op_q, alu_op_d;
  logic           res_id_q, res_id_d;
  logic [W-1:0]   res_f_q, res_f_d;
  logic           res_zf_q, res_zf_d;
  logic           res_of_q, res_of_d;
  logic           win;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign win = ~REQ0;
`else
  // rr_q names the requester favoured when both request together
  logic rr_q, rr_d;

  assign win = (REQ0 & REQ1) ? rr_q : REQ1;

  always_comb begin
    rr_d = rr_q;
    if (state_q == IDLE && (REQ0 | REQ1)) rr_d = ~win;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end
`endif

  always_comb begin
    state_d  = state_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done_d   = 1'b0;
    owner_d  = owner_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    res_id_d = res_id_q;
    res_f_d  = res_f_q;
    res_zf_d = res_zf_q;
    res_of_d = res_of_q;
    case (state_q)
      IDLE: begin
        if (REQ0 | REQ1) begin
          state_d  = EXEC;
          gnt0_d   = ~win;
          gnt1_d   = win;
          owner_d  = win;
          alu_a_d  = win ? A1  : A0;
          alu_b_d  = win ? B1  : B0;
          alu_op_d = win ? OP1 : OP0;
        end
      end
      EXEC: begin
        state_d  = RESP;
        res_id_d = owner_q;
        res_f_d  = ALU_F;
        res_zf_d = ALU_ZF;
        res_of_d = ALU_OF;
      end
      RESP: begin
        // DONE is registered, so it appears the cycle after RESP
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done_q   <= 1'b0;
      owner_q  <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      res_id_q <= 1'b0;
      res_f_q  <= '0;
      res_zf_q <= 1'b0;
      res_of_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done_q   <= done_d;
      owner_q  <= owner_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      res_id_q <= res_id_d;
      res_f_q  <= res_f_d;
      res_zf_q <= res_zf_d;
      res_of_q <= res_of_d;
    end
  end

  assign GNT0   = gnt0_q;
  assign GNT1   = gnt1_q;
  assign DONE   = done_q;
  assign ALU_A  = alu_a_q;
  assign ALU_B  = alu_b_q;
  assign ALU_OP = alu_op_q;
  assign RES_ID = res_id_q;
  assign RES_F  = res_f_q;
  assign RES_ZF = res_zf_q;
  assign RES_OF = res_of_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: directed cases plus randomized
// requesters checked against a transaction-level reference model.
module tb_alu_req_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [31:0] a0, b0, a1, b1;
  logic [2:0]  op0, op1;
  logic        gnt0, gnt1, done, res_id, res_zf, res_of;
  logic [31:0] alu_a, alu_b, alu_f, res_f;
  logic [2:0]  alu_op;
  logic        alu_zf, alu_of;

  int checks = 0;
  int errors = 0;

  // Reference model state: cycles since the last grant, favoured requester,
  // and the values every output should currently show.
  int          phase;
  bit          fav;
  bit          m_id;
  logic        e_gnt0, e_gnt1, e_done, e_res_id, e_res_zf, e_res_of;
  logic [31:0] e_alu_a, e_alu_b, e_res_f;
  logic [2:0]  e_alu_op;

  always #5 clk = ~clk;

  // ALU stub: add for opcode 4, xor otherwise
  assign alu_f  = (alu_op == 3'b100) ? alu_a + alu_b : alu_a ^ alu_b;
  assign alu_zf = (alu_f == 32'd0);
  assign alu_of = (alu_op == 3'b100) && (alu_a[31] == alu_b[31]) && (alu_f[31] != alu_a[31]);

  alu_req_arbiter #(.W(32), .OPW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .REQ0(req0), .A0(a0), .B0(b0), .OP0(op0), .GNT0(gnt0),
    .REQ1(req1), .A1(a1), .B1(b1), .OP1(op1), .GNT1(gnt1),
    .ALU_A(alu_a), .ALU_B(alu_b), .ALU_OP(alu_op),
    .ALU_F(alu_f), .ALU_ZF(alu_zf), .ALU_OF(alu_of),
    .DONE(done), .RES_ID(res_id), .RES_F(res_f), .RES_ZF(res_zf), .RES_OF(res_of)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic [31:0] x0, input logic [31:0] y0,
                               input logic [2:0] o0, input logic r1, input logic [31:0] x1,
                               input logic [31:0] y1, input logic [2:0] o1);
    req0 = r0; a0 = x0; b0 = y0; op0 = o0;
    req1 = r1; a1 = x1; b1 = y1; op1 = o1;
  endtask

  // Expected {OF, ZF, F} computed with wide signed arithmetic
  function automatic logic [33:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    longint      s;
    longint      maxv;
    logic [31:0] f;
    logic        of;
    maxv = 64'sh7FFF_FFFF;
    if (op == 3'b100) begin
      s  = longint'($signed(a)) + longint'($signed(b));
      f  = s[31:0];
      of = (s > maxv) || (s < -maxv - 1);
    end else begin
      f  = a ^ b;
      of = 1'b0;
    end
    return {of, (f == 32'd0), f};
  endfunction

  task automatic model_reset();
    phase = 0; fav = 1'b0; m_id = 1'b0;
    e_gnt0 = 0; e_gnt1 = 0; e_done = 0; e_res_id = 0; e_res_zf = 0; e_res_of = 0;
    e_alu_a = 0; e_alu_b = 0; e_alu_op = 0; e_res_f = 0;
  endtask

  // Predicts the outputs after the coming rising edge from the current inputs
  task automatic model_step();
    bit          win;
    logic [33:0] r;
    e_gnt0 = 0; e_gnt1 = 0; e_done = 0;
    if (phase == 0) begin
      if (req0 || req1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        win = !req0;
`else
        win = (req0 && req1) ? fav : req1;
        fav = !win;
`endif
        m_id = win;
        e_gnt0 = !win; e_gnt1 = win;
        e_alu_a  = win ? a1  : a0;
        e_alu_b  = win ? b1  : b0;
        e_alu_op = win ? op1 : op0;
        phase = 1;
      end
    end else if (phase == 1) begin
      r = ref_alu(e_alu_a, e_alu_b, e_alu_op);
      e_res_f = r[31:0]; e_res_zf = r[32]; e_res_of = r[33];
      e_res_id = m_id;
      phase = 2;
    end else begin
      e_done = 1;
      phase = 0;
    end
  endtask

  task automatic compare_all();
    checkOutput("gnt0",   32'(gnt0),   32'(e_gnt0));
    checkOutput("gnt1",   32'(gnt1),   32'(e_gnt1));
    checkOutput("done",   32'(done),   32'(e_done));
    checkOutput("alu_a",  alu_a,       e_alu_a);
    checkOutput("alu_b",  alu_b,       e_alu_b);
    checkOutput("alu_op", 32'(alu_op), 32'(e_alu_op));
    checkOutput("res_id", 32'(res_id), 32'(e_res_id));
    checkOutput("res_f",  res_f,       e_res_f);
    checkOutput("res_zf", 32'(res_zf), 32'(e_res_zf));
    checkOutput("res_of", 32'(res_of), 32'(e_res_of));
  endtask

  task automatic step_cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  // Asserts reset asynchronously and checks every output clears at once
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [2:0] rand_op();
    if ($urandom_range(0, 1) == 1) return 3'b100;
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic run_directed_op(input bit who, input logic [31:0] x, input logic [31:0] y,
                                 input string name, input logic [31:0] exp_f,
                                 input logic exp_zf, input logic exp_of);
    if (who) applyStimulus(0, 0, 0, 0, 1, x, y, 3'b100);
    else     applyStimulus(1, x, y, 3'b100, 0, 0, 0, 0);
    step_cycle();
    checkOutput({name, "_gnt"},   32'(who ? gnt1 : gnt0), 32'd1);
    checkOutput({name, "_alu_a"}, alu_a, x);
    checkOutput({name, "_alu_b"}, alu_b, y);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step_cycle();
    checkOutput({name, "_gnt_pulse"}, 32'(gnt0 | gnt1), 32'd0);
    step_cycle();
    checkOutput({name, "_done"},   32'(done),   32'd1);
    checkOutput({name, "_res_f"},  res_f,       exp_f);
    checkOutput({name, "_res_id"}, 32'(res_id), 32'(who));
    checkOutput({name, "_res_zf"}, 32'(res_zf), 32'(exp_zf));
    checkOutput({name, "_res_of"}, 32'(res_of), 32'(exp_of));
  endtask

  initial begin
    int c0;
    int c1;
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    do_reset();

    // Both requesters held continuously
    applyStimulus(1, $urandom(), $urandom(), 3'b100, 1, $urandom(), $urandom(), 3'b100);
    c0 = 0; c1 = 0;
    for (int i = 0; i < 12; i++) begin
      step_cycle();
      if (gnt0) c0++;
      if (gnt1) c1++;
    end
`ifdef ALU_ARB_FIXED_PRIO_EN
    checkOutput("both_gnt0_count", 32'(c0), 32'd4);
    checkOutput("both_gnt1_count", 32'(c1), 32'd0);
`else
    checkOutput("both_gnt0_count", 32'(c0), 32'd2);
    checkOutput("both_gnt1_count", 32'(c1), 32'd2);
`endif
    req0 = 1'b0;
    step_cycle();
    checkOutput("gnt1_after_req0_drop", 32'(gnt1), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step_cycle();
    step_cycle();

    run_directed_op(1'b0, 32'h3,         32'h607,       "add_small", 32'h60A,       1'b0, 1'b0);
    run_directed_op(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, "add_ovf",   32'hFFFF_FFFE, 1'b0, 1'b1);
    run_directed_op(1'b1, 32'h8000_0000, 32'h8000_0000, "add_neg",   32'h0,         1'b1, 1'b1);

    // Reset while an op is in flight: no DONE may follow
    applyStimulus(1, rand_word(), rand_word(), rand_op(), 0, 0, 0, 0);
    step_cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step_cycle();
      checkOutput("no_done_after_reset", 32'(done), 32'd0);
    end

    // Randomized requesters; a granted requester drops or issues a new request
    for (int i = 0; i < 400; i++) begin
      if (e_gnt0) begin
        if ($urandom_range(0, 1) == 1) req0 = 1'b0;
        else begin req0 = 1'b1; a0 = rand_word(); b0 = rand_word(); op0 = rand_op(); end
      end else if (!req0) begin
        if ($urandom_range(0, 9) < 4) begin req0 = 1'b1; a0 = rand_word(); b0 = rand_word(); op0 = rand_op(); end
      end else if ($urandom_range(0, 19) == 0) req0 = 1'b0;
      if (e_gnt1) begin
        if ($urandom_range(0, 1) == 1) req1 = 1'b0;
        else begin req1 = 1'b1; a1 = rand_word(); b1 = rand_word(); op1 = rand_op(); end
      end else if (!req1) begin
        if ($urandom_range(0, 9) < 4) begin req1 = 1'b1; a1 = rand_word(); b1 = rand_word(); op1 = rand_op(); end
      end else if ($urandom_range(0, 19) == 0) req1 = 1'b0;
      step_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
